// File: rtl/xor_unit_bist.sv
// Purpose: built-in self-test for the ALU XOR unit; drives corner + LFSR vectors, checks C against A^B.
// Latency: done rises NUM_VECTORS+LAT+1 cycles after start is accepted.
// Backpressure: none; start is only sampled in IDLE/DONE and ignored while busy.
module xor_unit_bist #(
    parameter int          WIDTH       = 32,
    parameter int          NUM_VECTORS = 256,
    parameter int          LAT         = 0,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] SEED_A      = 32'hACE11234,
    parameter logic [31:0] SEED_B      = 32'h5EED0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] c_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_idx,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [31:0]      POLY       = 32'h80200003;
    localparam logic [31:0]      PAT_A      = 32'hAAAAAAAA;
    localparam logic [31:0]      PAT_B      = 32'h55555555;
    localparam logic [31:0]      SEED_A_NZ  = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0]      SEED_B_NZ  = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_VECTORS - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'(LAT);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       drain_cnt;
    logic [31:0]      lfsr_a, lfsr_b;
    logic             accept;
    logic             drive_vld;
    logic [WIDTH-1:0] exp_now;
    logic [WIDTH-1:0] exp_d;
    logic [CNT_W-1:0] idx_d;
    logic             vld_d;
    logic             cmp_vld, cmp_miss;
    logic [CNT_W-1:0] cmp_idx;
    logic [CNT_W-1:0] err_nxt, first_nxt;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign drive_vld = (state == S_DRIVE);
    assign busy      = (state == S_DRIVE) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign exp_now   = a_out ^ b_out;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
            S_DRIVE:        if (vec_idx == LAST_IDX) state_nxt = S_DRAIN;
            // DRAIN covers the LAT-deep pipe plus the registered compare stage
            S_DRAIN:        if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Vector k is loaded while vec_idx still holds k-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out   <= '0;
            b_out   <= '0;
            vec_idx <= '0;
            lfsr_a  <= SEED_A_NZ;
            lfsr_b  <= SEED_B_NZ;
        end else if (accept) begin
            a_out   <= '0;
            b_out   <= '0;
            vec_idx <= '0;
            lfsr_a  <= SEED_A_NZ;
            lfsr_b  <= SEED_B_NZ;
        end else if (state == S_DRIVE) begin
            if (vec_idx == LAST_IDX) begin
                a_out <= '0;
                b_out <= '0;
            end else begin
                vec_idx <= vec_idx + CNT_W'(1);
                if (vec_idx == CNT_W'(0)) begin
                    a_out <= '1;
                    b_out <= '0;
                end else if (vec_idx == CNT_W'(1)) begin
                    a_out <= '1;
                    b_out <= '1;
                end else if (vec_idx == CNT_W'(2)) begin
                    a_out <= PAT_A[WIDTH-1:0];
                    b_out <= PAT_B[WIDTH-1:0];
                end else begin
                    a_out  <= lfsr_a[WIDTH-1:0];
                    b_out  <= lfsr_b[WIDTH-1:0];
                    lfsr_a <= lfsr_step(lfsr_a);
                    lfsr_b <= lfsr_step(lfsr_b);
                end
            end
        end
    end

    generate
        if (LAT > 0) begin : g_pipe
            logic [WIDTH-1:0] pipe_exp [LAT];
            logic [CNT_W-1:0] pipe_idx [LAT];
            logic             pipe_vld [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        pipe_exp[i] <= '0;
                        pipe_idx[i] <= '0;
                        pipe_vld[i] <= 1'b0;
                    end
                end else begin
                    pipe_exp[0] <= exp_now;
                    pipe_idx[0] <= vec_idx;
                    pipe_vld[0] <= drive_vld;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_exp[i] <= pipe_exp[i-1];
                        pipe_idx[i] <= pipe_idx[i-1];
                        pipe_vld[i] <= pipe_vld[i-1];
                    end
                end
            end

            assign exp_d = pipe_exp[LAT-1];
            assign idx_d = pipe_idx[LAT-1];
            assign vld_d = pipe_vld[LAT-1];
        end else begin : g_nopipe
            assign exp_d = exp_now;
            assign idx_d = vec_idx;
            assign vld_d = drive_vld;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_vld  <= 1'b0;
            cmp_miss <= 1'b0;
            cmp_idx  <= '0;
        end else begin
            cmp_vld  <= vld_d;
            cmp_miss <= (c_in != exp_d);
            cmp_idx  <= idx_d;
        end
    end

    always_comb begin
        err_nxt   = err_count;
        first_nxt = first_err_idx;
        if (cmp_vld && cmp_miss) begin
            if (err_count != '1) err_nxt = err_count + CNT_W'(1);
            if (first_err_idx == '1) first_nxt = cmp_idx;
        end
    end

    // pass is evaluated on err_nxt so the final compare is included when done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count     <= '0;
            first_err_idx <= '1;
            pass          <= 1'b0;
        end else if (accept) begin
            err_count     <= '0;
            first_err_idx <= '1;
            pass          <= 1'b0;
        end else begin
            err_count     <= err_nxt;
            first_err_idx <= first_nxt;
            if ((state == S_DRAIN) && (state_nxt == S_DONE)) pass <= (err_nxt == '0);
        end
    end

endmodule

// File: tb/tb_xor_unit_bist.sv
// Bench for xor_unit_bist: scoreboard of expected vectors and run results against a faultable XOR unit.
// A second small instance covers LAT=0 and error-count saturation.
module tb_xor_unit_bist;

    localparam int W   = 32;
    localparam int N   = 40;
    localparam int L   = 2;
    localparam int CW  = 16;
    localparam int W2  = 8;
    localparam int N2  = 15;
    localparam int CW2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start;
    logic [W-1:0]  a_out, b_out, c_in;
    logic          busy, done, pass;
    logic [CW-1:0] vec_idx, err_count, first_err_idx;

    logic           start2;
    logic [W2-1:0]  a2, b2, c2;
    logic           busy2, done2, pass2;
    logic [CW2-1:0] vec_idx2, err2, first2;
    logic           inv2;

    xor_unit_bist #(.WIDTH(W), .NUM_VECTORS(N), .LAT(L), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out), .c_in(c_in),
        .busy(busy), .done(done), .pass(pass), .vec_idx(vec_idx), .err_count(err_count),
        .first_err_idx(first_err_idx));

    xor_unit_bist #(.WIDTH(W2), .NUM_VECTORS(N2), .LAT(0), .CNT_W(CW2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2), .c_in(c2),
        .busy(busy2), .done(done2), .pass(pass2), .vec_idx(vec_idx2), .err_count(err2),
        .first_err_idx(first2));

    // Unit under test: 2-stage registered XOR with selectable fault
    // mode 0 ideal, 1 bit fbit stuck-at-0, 2 inverted output, 3 only 1 stage of latency
    int           mode = 0;
    int           fbit = 5;
    logic [W-1:0] s1 = '0, s2 = '0;
    always @(posedge clk) begin
        s1 <= a_out ^ b_out;
        s2 <= s1;
    end
    always_comb begin
        c_in = s2;
        case (mode)
            1:       c_in = s2 & ~(W'(1) << fbit);
            2:       c_in = ~s2;
            3:       c_in = s1;
            default: c_in = s2;
        endcase
    end
    assign c2 = inv2 ? ~(a2 ^ b2) : (a2 ^ b2);

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [CW-1:0] idx;
    } vec_t;
    typedef struct packed {
        logic [CW-1:0] err;
        logic [CW-1:0] first;
        logic          pass;
    } res_t;

    vec_t vq[$];
    res_t rq[$];

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    // Reference model: whole run's vectors and the resulting verdict for the chosen fault.
    task automatic issue_run(input int m);
        logic [31:0]  la, lb;
        logic [W-1:0] xs[$];
        vec_t         v;
        res_t         r;
        int           e, f;
        bit           miss;
        la = 32'hACE11234;
        lb = 32'h5EED0001;
        e  = 0;
        f  = -1;
        for (int k = 0; k < N; k++) begin
            case (k)
                0: begin v.a = '0; v.b = '0; end
                1: begin v.a = '1; v.b = '0; end
                2: begin v.a = '1; v.b = '1; end
                3: begin v.a = 32'hAAAAAAAA; v.b = 32'h55555555; end
                default: begin
                    v.a = la;
                    v.b = lb;
                    la  = lfsr_next(la);
                    lb  = lfsr_next(lb);
                end
            endcase
            v.idx = CW'(k);
            vq.push_back(v);
            xs.push_back(v.a ^ v.b);
        end
        xs.push_back('0);  // operands are zero once driving ends
        for (int k = 0; k < N; k++) begin
            case (m)
                1:       miss = xs[k][fbit];
                2:       miss = 1'b1;
                3:       miss = (xs[k+1] != xs[k]);
                default: miss = 1'b0;
            endcase
            if (miss) begin
                if (f < 0) f = k;
                e++;
            end
        end
        r.err   = (e >= (1 << CW) - 1) ? '1 : CW'(e);
        r.first = (f < 0) ? '1 : CW'(f);
        r.pass  = (e == 0);
        rq.push_back(r);
    endtask

    // Monitor: vectors while busy, verdict and timing on each rising done
    int   cyc = 0;
    int   t0  = 0;
    logic pb  = 1'b0;
    logic pd  = 1'b0;
    vec_t mv;
    res_t mr;
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (busy && !pb) t0 = cyc;
            if (busy && vq.size() > 0) begin
                mv = vq.pop_front();
                chk("a_out", a_out, mv.a);
                chk("b_out", b_out, mv.b);
                chk("vec_idx", vec_idx, mv.idx);
            end
            if (done && !pd) begin
                chk("done_expected", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    mr = rq.pop_front();
                    chk("err_count", err_count, mr.err);
                    chk("first_err_idx", first_err_idx, mr.first);
                    chk("pass", pass, mr.pass);
                    chk("done_cycle", cyc - t0, N + L + 1);
                end
            end
        end
        pb = busy;
        pd = done;
    end

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < N + L + 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_timeout", got, 1);
    endtask

    task automatic do_run(input int m);
        mode = m;
        issue_run(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    task automatic run_sat(input logic inv, input logic [CW2-1:0] e_err,
                           input logic [CW2-1:0] e_first, input logic e_pass);
        int cnt;
        inv2   = inv;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cnt    = 1;
        for (int i = 0; i < N2 + 20; i++) begin
            if (cnt == 2) begin
                chk("sat_a_k1", a2, 8'hFF);
                chk("sat_b_k1", b2, 8'h00);
            end
            if (done2) break;
            @(negedge clk);
            cnt++;
        end
        chk("sat_done", done2, 1);
        chk("sat_done_cycle", cnt, N2 + 2);
        chk("sat_err", err2, e_err);
        chk("sat_first", first2, e_first);
        chk("sat_pass", pass2, e_pass);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        inv2   = 1'b0;
        #12;
        chk("rst_a_out", a_out, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_vec_idx", vec_idx, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_idx, 16'hFFFF);
        chk("rst_first2", first2, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(0);
        fbit = 5;
        do_run(1);
        fbit = $urandom_range(0, 31);
        do_run(1);
        do_run(2);
        do_run(3);

        // Abort mid-run with an asynchronous reset between clock edges
        mode = 0;
        issue_run(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (vec_idx == CW'(7)) break;
            @(negedge clk);
        end
        chk("abort_reached_idx7", vec_idx, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_a_out", a_out, 0);
        chk("abort_vec_idx", vec_idx, 0);
        chk("abort_err", err_count, 0);
        chk("abort_first", first_err_idx, 16'hFFFF);
        vq.delete();
        rq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_run(0);

        // start held through the whole run, then a rerun accepted from DONE
        issue_run(0);
        start = 1'b1;
        @(negedge clk);
        wait_done();
        issue_run(0);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        run_sat(1'b0, 4'h0, 4'hF, 1'b1);
        run_sat(1'b1, 4'hF, 4'h0, 1'b0);

        chk("vq_drained", vq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
